// File: rtl/vigenere_stream_ctrl_if.sv
// rtl/vigenere_stream_ctrl_if.sv - handshake bundle for the keyed byte cipher stream controller
interface vigenere_stream_ctrl_if #(
  parameter int LEN_W = 16
) ();
  logic             key_valid;
  logic [7:0]       key_data;
  logic             key_ready;
  logic             start;
  logic             mode;
  logic [LEN_W-1:0] msg_len;
  logic             abort;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_last;
  logic             out_ready;
  logic             key_loaded;
  logic             busy;
  logic             done;
  logic             err;

  modport slave (
    input  key_valid, key_data, start, mode, msg_len, abort, in_valid, in_data, out_ready,
    output key_ready, in_ready, out_valid, out_data, out_last, key_loaded, busy, done, err
  );

  modport master (
    output key_valid, key_data, start, mode, msg_len, abort, in_valid, in_data, out_ready,
    input  key_ready, in_ready, out_valid, out_data, out_last, key_loaded, busy, done, err
  );
endinterface

// File: rtl/vigenere_stream_ctrl.sv
// rtl/vigenere_stream_ctrl.sv - key loader and rotating-key add/subtract byte stream engine
module vigenere_stream_ctrl #(
  parameter int SEC_LEN = 3,
  parameter int LEN_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  vigenere_stream_ctrl_if.slave bus
);
  localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;
  localparam logic [KW-1:0] KLAST = KW'(SEC_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       key_q [SEC_LEN];
  logic [KW-1:0]    key_wr_idx_q, key_wr_idx_d;
  logic             key_loaded_q, key_loaded_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [KW-1:0]    kidx_q, kidx_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic key_ready, in_ready, key_fire, in_fire, out_fire, last_in;
  logic [7:0] key_byte;

  assign key_ready = (state_q == S_IDLE);
  // The single output register may be refilled in the same cycle it drains.
  assign in_ready  = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
  assign key_fire  = bus.key_valid && key_ready;
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = out_valid_q && bus.out_ready;
  assign key_byte  = key_q[kidx_q];
  assign last_in   = (cnt_q == len_q - LEN_W'(1));

  // Next-state logic for key bookkeeping, sequencing FSM and output register
  always_comb begin
    state_d      = state_q;
    key_wr_idx_d = key_wr_idx_q;
    key_loaded_d = key_loaded_q;
    mode_d       = mode_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    kidx_d       = kidx_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    // Rewriting byte 0 invalidates the key until the last byte lands again.
    if (key_fire) begin
      if (key_wr_idx_q == '0) key_loaded_d = 1'b0;
      if (key_wr_idx_q == KLAST) begin
        key_loaded_d = 1'b1;
        key_wr_idx_d = '0;
      end else begin
        key_wr_idx_d = key_wr_idx_q + KW'(1);
      end
    end

    if (bus.abort) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      cnt_d       = '0;
      kidx_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // key_loaded_q is the pre-write value, so a same-cycle key byte cannot enable this start.
          if (bus.start) begin
            if (!key_loaded_q) begin
              err_d = 1'b1;
            end else if (bus.msg_len == '0) begin
              done_d = 1'b1;
            end else begin
              mode_d  = bus.mode;
              len_d   = bus.msg_len;
              cnt_d   = '0;
              kidx_d  = '0;
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (in_fire) begin
            out_data_d  = mode_q ? (bus.in_data - key_byte) : (bus.in_data + key_byte);
            out_valid_d = 1'b1;
            out_last_d  = last_in;
            cnt_d       = cnt_q + LEN_W'(1);
            kidx_d      = (kidx_q == KLAST) ? '0 : kidx_q + KW'(1);
            if (last_in) state_d = S_DRAIN;
          end else if (out_fire) begin
            out_valid_d = 1'b0;
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      key_wr_idx_q <= '0;
      key_loaded_q <= 1'b0;
      mode_q       <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      kidx_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_wr_idx_q <= key_wr_idx_d;
      key_loaded_q <= key_loaded_d;
      mode_q       <= mode_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      kidx_q       <= kidx_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Key byte storage, written at the current write index on each key handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SEC_LEN; i++) key_q[i] <= '0;
    end else if (key_fire) begin
      key_q[key_wr_idx_q] <= bus.key_data;
    end
  end

  assign bus.key_ready  = key_ready;
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.key_loaded = key_loaded_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_vigenere_stream_ctrl.sv
// tb/tb_vigenere_stream_ctrl.sv - self-checking bench for vigenere_stream_ctrl
module tb_vigenere_stream_ctrl;
  localparam int LEN_W = 16;

  typedef struct packed {
    logic        mode;
    logic [2:0]  len;
    logic [39:0] din;
    logic [39:0] dout;
  } vec_t;

  logic clk, rst;
  vigenere_stream_ctrl_if #(.LEN_W(LEN_W)) bif ();

  vigenere_stream_ctrl #(.SEC_LEN(3), .LEN_W(LEN_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bif)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_hs_cyc = -100;
  logic [8:0] sb[$];
  logic held = 1'b0;
  logic [8:0] held_v;
  vec_t vecs [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard pop on handshake, backpressure stability
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("bp_hold_valid", 32'(bif.out_valid), 1);
        check("bp_hold_data", 32'({bif.out_last, bif.out_data}), 32'(held_v));
      end
      if (bif.out_valid && !bif.out_ready) begin
        check("bp_in_ready", 32'(bif.in_ready), 0);
        held = 1'b1;
        held_v = {bif.out_last, bif.out_data};
      end else begin
        held = 1'b0;
      end
      if (bif.out_valid && bif.out_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          logic [8:0] e;
          e = sb.pop_front();
          check("out_byte", 32'({bif.out_last, bif.out_data}), 32'(e));
          if (e[8]) last_hs_cyc = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    bif.key_valid = 1'b1;
    bif.key_data = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.key_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("key_accept_timeout", 0, 1);
    tick();
    bif.key_valid = 1'b0;
  endtask

  task automatic do_start(input logic m, input logic [LEN_W-1:0] len);
    bif.start = 1'b1;
    bif.mode = m;
    bif.msg_len = len;
    tick();
    bif.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [7:0] e, input logic last, output int acc);
    logic ok;
    ok = 1'b0;
    acc = -1;
    bif.in_valid = 1'b1;
    bif.in_data = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bif.in_ready) begin
        ok = 1'b1;
        acc = cyc;
        sb.push_back({last, e});
        break;
      end
    end
    if (!ok) check("in_accept_timeout", 0, 1);
    tick();
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bif.done) begin ok = 1'b1; break; end
    end
    check({name, "_done_seen"}, 32'(ok), 1);
    if (ok) check({name, "_done_latency"}, 32'(cyc - last_hs_cyc), 1);
    @(negedge clk);
    check({name, "_done_pulse_width"}, 32'(bif.done), 0);
    check({name, "_sb_drained"}, 32'(sb.size()), 0);
    check({name, "_idle"}, 32'(bif.busy), 0);
  endtask

  task automatic run_vec(input string name, input vec_t v, input logic chk_tp);
    int acc, first_acc, last_acc;
    first_acc = 0;
    last_acc = 0;
    do_start(v.mode, LEN_W'(v.len));
    for (int i = 0; i < int'(v.len); i++) begin
      send_byte(v.din[8*i +: 8], v.dout[8*i +: 8], i == int'(v.len) - 1, acc);
      if (i == 0) first_acc = acc;
      last_acc = acc;
    end
    if (chk_tp) check({name, "_throughput"}, 32'(last_acc - first_acc), 32'(v.len) - 1);
    wait_done(name);
  endtask

  initial begin
    int acc, n;
    vec_t v;
    vecs[0] = '{mode: 1'b0, len: 3'd1, din: 40'h00_00_00_00_48, dout: 40'h00_00_00_00_93};
    vecs[1] = '{mode: 1'b0, len: 3'd5, din: 40'h4F_4C_4C_45_48, dout: 40'h94_97_A5_8A_93};
    vecs[2] = '{mode: 1'b1, len: 3'd5, din: 40'h94_97_A5_8A_93, dout: 40'h4F_4C_4C_45_48};
    vecs[3] = '{mode: 1'b0, len: 3'd1, din: 40'h00_00_00_00_F0, dout: 40'h00_00_00_00_3B};
    vecs[4] = '{mode: 1'b1, len: 3'd4, din: 40'h00_00_00_00_00, dout: 40'h00_B5_A7_BB_B5};

    rst = 1'b1;
    bif.key_valid = 1'b0; bif.key_data = '0; bif.start = 1'b0; bif.mode = 1'b0;
    bif.msg_len = '0; bif.abort = 1'b0; bif.in_valid = 1'b0; bif.in_data = '0;
    bif.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_key_ready", 32'(bif.key_ready), 1);
    check("rst_in_ready", 32'(bif.in_ready), 0);
    check("rst_out_valid", 32'(bif.out_valid), 0);
    check("rst_out_data", 32'(bif.out_data), 0);
    check("rst_out_last", 32'(bif.out_last), 0);
    check("rst_key_loaded", 32'(bif.key_loaded), 0);
    check("rst_busy", 32'(bif.busy), 0);
    check("rst_done", 32'(bif.done), 0);
    check("rst_err", 32'(bif.err), 0);
    tick();

    do_start(1'b0, 16'd5);
    @(negedge clk);
    check("nokey_err", 32'(bif.err), 1);
    check("nokey_busy", 32'(bif.busy), 0);
    @(negedge clk);
    check("nokey_err_pulse", 32'(bif.err), 0);
    tick();

    send_key(8'h4B);
    send_key(8'h45);
    check("partial_key_loaded", 32'(bif.key_loaded), 0);
    do_start(1'b0, 16'd5);
    @(negedge clk);
    check("partial_key_err", 32'(bif.err), 1);
    tick();
    send_key(8'h59);
    check("key_loaded", 32'(bif.key_loaded), 1);

    do_start(1'b0, 16'd0);
    @(negedge clk);
    check("len0_done", 32'(bif.done), 1);
    check("len0_out_valid", 32'(bif.out_valid), 0);
    check("len0_busy", 32'(bif.busy), 0);
    check("len0_err", 32'(bif.err), 0);
    tick();

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b1);

    // Sink stalls for three cycles with a byte pending mid-message
    fork
      run_vec("backpressure", vecs[1], 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 bif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bif.out_ready = 1'b1;
      end
    join
    tick();

    // Abort after two of five bytes, then restart with the retained key
    do_start(1'b0, 16'd5);
    send_byte(8'h48, 8'h93, 1'b0, acc);
    send_byte(8'h45, 8'h8A, 1'b0, acc);
    bif.abort = 1'b1;
    tick();
    bif.abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bif.busy), 0);
    check("abort_out_valid", 32'(bif.out_valid), 0);
    check("abort_key_loaded", 32'(bif.key_loaded), 1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bif.done) n++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(n), 0);
    check("abort_sb_empty", 32'(sb.size()), 0);
    tick();
    v = '{mode: 1'b0, len: 3'd3, din: 40'h00_00_4C_45_48, dout: 40'h00_00_A5_8A_93};
    run_vec("abort_restart", v, 1'b1);

    // Simultaneous start and abort in IDLE: abort wins
    bif.abort = 1'b1;
    do_start(1'b0, 16'd2);
    bif.abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", 32'(bif.busy), 0);
    tick();

    // Reloading the key clears key_loaded until all bytes are rewritten
    send_key(8'h01);
    check("reload_cleared", 32'(bif.key_loaded), 0);
    send_key(8'h02);
    send_key(8'h03);
    check("reload_loaded", 32'(bif.key_loaded), 1);
    v = '{mode: 1'b0, len: 3'd4, din: 40'h00_10_10_10_10, dout: 40'h00_11_13_12_11};
    run_vec("new_key", v, 1'b1);

    // Reset mid-message clears everything including the key
    do_start(1'b0, 16'd3);
    send_byte(8'h20, 8'h21, 1'b0, acc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_key_loaded", 32'(bif.key_loaded), 0);
    check("midrst_busy", 32'(bif.busy), 0);
    check("midrst_out_valid", 32'(bif.out_valid), 0);
    check("midrst_out_data", 32'(bif.out_data), 0);
    tick();
    do_start(1'b0, 16'd1);
    @(negedge clk);
    check("midrst_start_err", 32'(bif.err), 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
